// File: rtl/counter_down_load_pkg.sv
// Shared types for the presettable down-counter/timer: FSM states and the count's zero value.
package counter_down_load_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam int unsigned CNT_ZERO = 0;

endpackage

// File: rtl/counter_down_load_core.sv
// WIDTH-bit count register with load, saturating decrement and zero detect.
module down_count_core
  import counter_down_load_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             dec,
  output logic [WIDTH-1:0] q,
  output logic             zero
);

  assign zero = (q == WIDTH'(CNT_ZERO));

  // Decrement is gated by zero so the count can never wrap to all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= WIDTH'(CNT_ZERO);
    end else if (ld) begin
      q <= ld_val;
    end else if (dec && !zero) begin
      q <= q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_down_load.sv
// Presettable, cascadable down-counter: counts en pulses down from a preset, raises
// combinational borrow Bc at terminal count, then stops (one-shot) or reloads.
module counter_down_load
  import counter_down_load_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             mode,
  output logic [WIDTH-1:0] Q,
  output logic             Bc,
  output logic             done,
  output logic             busy
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] preset;
  logic             core_ld;
  logic [WIDTH-1:0] core_val;
  logic             core_dec;
  logic             zero;

  down_count_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (core_ld),
    .ld_val (core_val),
    .dec    (core_dec),
    .q      (Q),
    .zero   (zero)
  );

  assign Bc   = en && (state == RUN) && zero;
  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      preset <= WIDTH'(CNT_ZERO);
      done   <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= Bc;
      if (load) begin
        preset <= D;
      end
    end
  end

  // Load outranks counting in every state; terminal count either expires or reloads.
  always_comb begin
    state_nx = state;
    core_ld  = 1'b0;
    core_val = D;
    core_dec = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          core_ld  = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (load) begin
          core_ld = 1'b1;
        end else if (en) begin
          if (!zero) begin
            core_dec = 1'b1;
          end else if (mode) begin
            core_ld  = 1'b1;
            core_val = preset;
          end else begin
            state_nx = EXPIRED;
          end
        end
      end
      EXPIRED: begin
        if (load) begin
          core_ld  = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: doc/counter_down_load.md
Name: counter_down_load

Overview:
- Presettable, cascadable down-counter/timer. It is the counterpart of the free-running 4-bit up-counter with ripple-carry (Rc) output.
- Consumes an upstream Rc/enable pulse, counts down from a loaded preset, and raises a borrow (Bc) at terminal count.
- Used as a programmable divider/timeout stage in the lab framework, between a counter chain and the display/ALU logic.

Parameters:
- WIDTH, 4, counter width in bits; must be ≥ 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable; typically the upstream Rc. Sampled on the rising clk edge.
- load  input  1  synchronous load strobe; copies D into both Q and the preset register.
- D  input  WIDTH  preset value.
- mode  input  1  0 = one-shot (stop at zero), 1 = auto-reload from the preset register.
- Q  output  WIDTH  current count. Q[0] corresponds to Qa, Q[WIDTH-1] to the MSB.
- Bc  output  1  combinational borrow for cascading: Bc = en & (state==RUN) & (Q==0).
- done  output  1  registered one-cycle pulse; asserted the cycle after any cycle in which Bc=1.
- busy  output  1  high while state==RUN.

Behaviour:
- Decided interface: one clock; reset is asynchronous and active-low. The clock port is clk and the reset port is rst_n.
- Reset (rst_n=0, immediate, any state): Q=0, preset=0, state=IDLE, done=0, busy=0. Bc=0 follows combinationally.
- States: IDLE, RUN, EXPIRED.
- Priority on each edge: reset > load > count.

IDLE:
- Q holds its value; en is ignored.
- load=1 → Q<=D, preset<=D, next state RUN.

RUN:
- load=1 → Q<=D, preset<=D, stay in RUN. Load wins over a simultaneous en, and no Bc-triggered action occurs that cycle.
- en=1 and Q≠0 → Q<=Q-1.
- en=1, Q==0, mode=0 → Q stays 0, next state EXPIRED, done<=1.
- en=1, Q==0, mode=1 → Q<=preset, stay in RUN, done<=1.
- en=0 → Q holds.

EXPIRED:
- Lasts exactly one cycle; Q=0, busy=0, Bc=0.
- Next state IDLE, unless load=1, which goes to RUN with Q<=D.

Timing and boundary rules:
- done is 1 only in the cycle immediately after a Bc=1 edge, otherwise 0. Back-to-back terminal counts give back-to-back done pulses.
- Latency: from load with value N, the counter needs N+1 enabled edges to reach terminal count.
  - Bc is high during the (N+1)-th enabled cycle.
  - done rises on that edge.
- Preset 0: the first enabled edge after load is terminal.
  - In mode=1 with preset 0, Bc is high on every en cycle and Q stays 0.
- Q only decrements from a nonzero value, so it never goes below 0 and never wraps to all-ones.
- Changing mode mid-RUN takes effect at the next terminal count. The preset register changes only on load.
- Reset asserted mid-count aborts immediately. After release the block sits in IDLE and ignores en until a load.
- Cascading: for a wider chain, the Bc of the lower stage drives en of the higher stage. Because Bc is combinational there is no extra cycle of skew. Downstream logic must treat Bc as valid only at the clock edge.

Decomposition:
- Shared package: state enum (IDLE, RUN, EXPIRED) and a localparam for the zero value of the count.
- One sub-module: down_count_core (WIDTH-bit register with load, decrement, zero-detect). The FSM stays in the top level.

Test Plan:
1. Reset and idle: rst_n low 3 cycles, then high; en pulses with no load → Q=0, busy=0, Bc=0, done=0 throughout.
2. One-shot count:
   - Stimulus: mode=0, load D=4'd3, then en=1 continuously.
   - Q sequence: 3,2,1,0.
   - Bc=1 in the cycle with Q=0; done=1 the next cycle.
   - The FSM passes through EXPIRED, then IDLE; Q stays 0 and busy=0.
3. Auto-reload:
   - Stimulus: mode=1, D=4'd2, en=1 for 9 cycles.
   - Q sequence: 2,1,0,2,1,0,2,1,0.
   - done pulses 3 times, spaced 3 cycles apart.
4. Gapped enable and priority:
   - D=4'd5, en toggling 1,0,1,0 → Q decrements only on en=1 edges.
   - With load D=4'd9 and en=1 in the same cycle → Q=9, not 8.
5. Edge values:
   - D=0, mode=1, en=1 → Bc=1 every cycle, done=1 every cycle, Q=0.
   - D=4'hF, mode=0 → Bc after 16 enabled edges; no wrap is observed.
6. Reset mid-operation and cascade:
   - rst_n low asynchronously at Q=6 → Q=0 immediately, before the next clk edge.
   - Cascade two instances, WIDTH=4: low Bc drives high en; load low=F, high=1 → high stage Bc asserts after 32 enabled cycles.
